ulight_fifo_led_pio_arbiter: RTL and testbench
==============================================

// Module: ulight_fifo_led_pio_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing the 5-bit LED PIO slave among NUM_REQ requesters.
//  Each requester posts an LED value and gets a one-cycle ack once the value is written.
//  Drives the PIO Avalon-MM slave port (address/chipselect/write_n/writedata/readdata) as its only master.
//  Sits between status sources (link FSM, FIFO flags, test logic) and the LED PIO.
// PARAMETERS
//  NUM_REQ  4  number of requesters, legal 2..8
//  LED_W    5  LED value width; must equal the PIO data_out width
//  (localparam GNT_W = clog2(NUM_REQ), min 1)
// PORTS
//  clk             in   1              system clock
//  reset_n         in   1              async active-low reset
//  req             in   NUM_REQ        per-requester write request, level
//  req_data        in   NUM_REQ*LED_W  requester i value at [i*LED_W +: LED_W]
//  ack             out  NUM_REQ        one-cycle pulse: requester's value written
//  pio_address     out  2              PIO address; always 0
//  pio_chipselect  out  1              PIO chipselect
//  pio_write_n     out  1              PIO write strobe, active low
//  pio_writedata   out  32             {(32-LED_W)'b0, value}
//  pio_readdata    in   32             PIO readdata (combinational in the PIO)
//  busy            out  1              high whenever state != IDLE
//  last_grant      out  GNT_W          index of most recently served requester
//  rb_err          out  1              sticky readback mismatch (macro only; else tied 0)
// BEHAVIOUR
//  Reset: state=IDLE, ack=0, pio_chipselect=0, pio_write_n=1, pio_address=0,
//   pio_writedata=0, busy=0, last_grant=0, rr pointer=0, rb_err=0. Reset mid-transfer aborts, no ack.
//  All outputs registered. States: IDLE, WRITE, [READ], ACK.
//  IDLE: if any req, pick first set bit scanning ptr, ptr+1, ... wrapping mod NUM_REQ;
//   latch grant index g and req_data slice into data_q; -> WRITE. No req: stay.
//  WRITE (1 cycle): chipselect=1, write_n=0, address=0, writedata={0,data_q}; PIO latches at end.
//   -> READ if macro enabled, else -> ACK.
//  ACK (1 cycle): ack[g]=1 only; chipselect=0, write_n=1; last_grant=g; ptr=(g+1) mod NUM_REQ; -> IDLE.
//  Throughput: 3 cycles per transaction (4 with macro); req seen in cycle 0 -> ack in cycle 2 (3).
//  Requester holds req until ack and must drop req the cycle after ack; a req still high
//   in IDLE is a new request (served after other pending requesters by round robin).
//  Data captured at grant; req_data/req changes after grant do not affect the write; ack still issued.
//  Wrap: g=NUM_REQ-1 -> ptr=0. Single requester continuously asserting is served every cycle budget.
//  Never more than one ack bit set; ack never while chipselect=1.
// CONFIGURATION
//  Macro LED_PIO_ARB_READBACK_EN:
//   defined: READ state after WRITE: chipselect=1, write_n=1, address=0; at end of READ sample
//    pio_readdata[LED_W-1:0]; if != data_q set rb_err (sticky until reset); then -> ACK.
//   undefined: no READ state, pio_readdata unused, rb_err tied 0.
// TESTING
//  Reset, no req -> chipselect=0, write_n=1, busy=0, ack=0 indefinitely.
//  req=0001, data0=5'h15 -> cycle1 cs=1/write_n=0/writedata=32'h15, cycle2 ack=0001, PIO out_port=5'h15.
//  req=1111 held, data i=i+1 -> grants 0,1,2,3,0 in order; each ack one cycle; last_grant follows.
//  ptr=3 after serving 2, req=1001 -> requester 3 served before 0 (wrap check).
//  reset_n low during WRITE -> outputs at reset values, no ack, ptr=0; req still high -> req0 served fresh.
//  Macro on: force pio_readdata=0 while writing 5'h1F -> READ cycle cs=1/write_n=1, rb_err=1 and stays 1.

Source files
------------

// File: rtl/ulight_fifo_led_pio_arbiter_if.sv
// ---------------------------------------------------------------------------
// ulight_fifo_led_pio_arbiter_if
//
// Purpose:
//   Avalon-MM bundle between the LED PIO arbiter (master) and the LED PIO
//   slave. Only the subset of Avalon-MM that the PIO implements is carried.
//
// Signals:
//   pio_address     master -> slave  2   register address (arbiter always uses 0)
//   pio_chipselect  master -> slave  1   slave select
//   pio_write_n     master -> slave  1   write strobe, active low
//   pio_writedata   master -> slave  32  write data
//   pio_readdata    slave  -> master 32  read data (combinational in the PIO)
//
// Modports:
//   master : used by the arbiter
//   slave  : used by the PIO (or a model of it)
// ---------------------------------------------------------------------------
interface ulight_fifo_led_pio_arbiter_if;

    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata;

    modport master (
        output pio_address,
        output pio_chipselect,
        output pio_write_n,
        output pio_writedata,
        input  pio_readdata
    );

    modport slave (
        input  pio_address,
        input  pio_chipselect,
        input  pio_write_n,
        input  pio_writedata,
        output pio_readdata
    );

endinterface : ulight_fifo_led_pio_arbiter_if

// File: rtl/ulight_fifo_led_pio_arbiter.sv
// ---------------------------------------------------------------------------
// ulight_fifo_led_pio_arbiter
//
// Purpose:
//   Round-robin arbiter/sequencer that shares the 5-bit LED PIO slave among
//   NUM_REQ requesters. Each requester posts an LED value on its slice of
//   req_data together with a level request; the arbiter grants one requester,
//   performs a single Avalon-MM write to the PIO and returns a one-cycle ack.
//   It is the only master of the PIO.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   LED_W    LED value width, equal to the PIO data_out width
//   GNT_W    derived grant index width, clog2(NUM_REQ) with a minimum of 1
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   req         in   per-requester write request (level)
//   req_data    in   requester i value at [i*LED_W +: LED_W]
//   ack         out  one-cycle pulse, the granted requester's value is written
//   pio         --   Avalon-MM master bundle towards the LED PIO
//   busy        out  high whenever the sequencer is not idle
//   last_grant  out  index of the most recently served requester
//   rb_err      out  sticky readback mismatch flag (0 without readback)
//
// Build option:
//   LED_PIO_ARB_READBACK_EN  when defined, every write is followed by a read
//                            of the PIO; a readback that differs from the
//                            written value sets rb_err until reset.
//
// Timing (all outputs registered):
//   cycle 0 IDLE sees req -> cycle 1 WRITE -> [READ] -> cycle 2 (3) ACK -> IDLE
// ---------------------------------------------------------------------------
module ulight_fifo_led_pio_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int LED_W   = 5,
    localparam int GNT_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*LED_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]         ack,
    ulight_fifo_led_pio_arbiter_if.master pio,
    output logic                       busy,
    output logic [GNT_W-1:0]           last_grant,
    output logic                       rb_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // Sequencer state and registered outputs.
    state_t              state_q,      state_d;
    logic [GNT_W-1:0]    ptr_q,        ptr_d;
    logic [GNT_W-1:0]    grant_q,      grant_d;
    logic [LED_W-1:0]    data_q,       data_d;
    logic [NUM_REQ-1:0]  ack_q,        ack_d;
    logic                cs_q,         cs_d;
    logic                write_n_q,    write_n_d;
    logic [31:0]         writedata_q,  writedata_d;
    logic                busy_q,       busy_d;
    logic [GNT_W-1:0]    last_grant_q, last_grant_d;

    // Round-robin pick results and helpers.
    logic                pick_found_s;
    logic [GNT_W-1:0]    pick_idx_s;
    logic [LED_W-1:0]    pick_data_s;
    logic [GNT_W-1:0]    next_ptr_s;
    logic                enter_ack_s;
    logic                rb_mismatch_s;

    // Upper readdata bits carry nothing for a 5-bit PIO; in the default
    // build the whole bus is ignored.
    logic                unused_rd_s;
    assign unused_rd_s = ^pio.pio_readdata;

    // Round-robin search: first set request bit starting at ptr_q, wrapping.
    always_comb begin
        int cand;
        logic [GNT_W-1:0] cand_idx;
        pick_found_s = 1'b0;
        pick_idx_s   = {GNT_W{1'b0}};
        cand         = 0;
        cand_idx     = {GNT_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end else begin
                cand = cand;
            end
            cand_idx = GNT_W'(cand);
            if (!pick_found_s && req[cand_idx]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_idx;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Value slice of the candidate requester, captured only on grant.
    always_comb begin
        pick_data_s = req_data[int'(pick_idx_s)*LED_W +: LED_W];
    end

    // Pointer after serving grant_q: one past the grant, wrapping to 0.
    always_comb begin
        if (grant_q == GNT_W'(NUM_REQ - 1)) begin
            next_ptr_s = {GNT_W{1'b0}};
        end else begin
            next_ptr_s = grant_q + {{(GNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Readback compare against the value that was just written.
`ifdef LED_PIO_ARB_READBACK_EN
    always_comb begin
        rb_mismatch_s = (pio.pio_readdata[LED_W-1:0] != data_q);
    end
`else
    always_comb begin
        rb_mismatch_s = 1'b0;
    end
`endif

    // Next-state and next-output logic of the write sequencer.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        data_d       = data_q;
        ack_d        = {NUM_REQ{1'b0}};
        cs_d         = cs_q;
        write_n_d    = write_n_q;
        writedata_d  = writedata_q;
        last_grant_d = last_grant_q;
        enter_ack_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    // Value is frozen here; later req_data changes are ignored.
                    state_d     = ST_WRITE;
                    grant_d     = pick_idx_s;
                    data_d      = pick_data_s;
                    cs_d        = 1'b1;
                    write_n_d   = 1'b0;
                    writedata_d = {{(32-LED_W){1'b0}}, pick_data_s};
                end else begin
                    state_d     = ST_IDLE;
                    cs_d        = 1'b0;
                    write_n_d   = 1'b1;
                end
            end
            ST_WRITE: begin
`ifdef LED_PIO_ARB_READBACK_EN
                state_d     = ST_READ;
                cs_d        = 1'b1;
                write_n_d   = 1'b1;
`else
                state_d     = ST_ACK;
                cs_d        = 1'b0;
                write_n_d   = 1'b1;
                enter_ack_s = 1'b1;
`endif
            end
`ifdef LED_PIO_ARB_READBACK_EN
            ST_READ: begin
                state_d     = ST_ACK;
                cs_d        = 1'b0;
                write_n_d   = 1'b1;
                enter_ack_s = 1'b1;
            end
`endif
            ST_ACK: begin
                state_d   = ST_IDLE;
                cs_d      = 1'b0;
                write_n_d = 1'b1;
            end
            default: begin
                state_d   = ST_IDLE;
                cs_d      = 1'b0;
                write_n_d = 1'b1;
            end
        endcase

        // ack, last_grant and the pointer all update on the way into ACK so
        // they are visible together during the ACK cycle.
        if (enter_ack_s) begin
            ack_d[grant_q] = 1'b1;
            last_grant_d   = grant_q;
            ptr_d          = next_ptr_s;
        end else begin
            ack_d          = ack_d;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= {GNT_W{1'b0}};
            grant_q      <= {GNT_W{1'b0}};
            data_q       <= {LED_W{1'b0}};
            ack_q        <= {NUM_REQ{1'b0}};
            cs_q         <= 1'b0;
            write_n_q    <= 1'b1;
            writedata_q  <= 32'h0000_0000;
            busy_q       <= 1'b0;
            last_grant_q <= {GNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            data_q       <= data_d;
            ack_q        <= ack_d;
            cs_q         <= cs_d;
            write_n_q    <= write_n_d;
            writedata_q  <= writedata_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef LED_PIO_ARB_READBACK_EN
    logic rb_err_q, rb_err_d;

    // Sticky error: set at the end of a READ cycle on mismatch.
    always_comb begin
        if ((state_q == ST_READ) && rb_mismatch_s) begin
            rb_err_d = 1'b1;
        end else begin
            rb_err_d = rb_err_q;
        end
    end

    // Sticky readback error register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rb_err_q <= 1'b0;
        end else begin
            rb_err_q <= rb_err_d;
        end
    end

    assign rb_err = rb_err_q;
`else
    logic unused_rb_s;
    assign unused_rb_s = rb_mismatch_s;
    assign rb_err      = 1'b0;
`endif

    assign ack                = ack_q;
    assign busy               = busy_q;
    assign last_grant         = last_grant_q;
    assign pio.pio_address    = 2'b00;
    assign pio.pio_chipselect = cs_q;
    assign pio.pio_write_n    = write_n_q;
    assign pio.pio_writedata  = writedata_q;

endmodule : ulight_fifo_led_pio_arbiter

// File: tb/tb_ulight_fifo_led_pio_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ulight_fifo_led_pio_arbiter
//
// Directed, table-driven bench for the LED PIO arbiter with NUM_REQ=4 and
// LED_W=5. A tiny PIO register model sits on the slave side of the bus.
// ---------------------------------------------------------------------------
module tb_ulight_fifo_led_pio_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LED_W   = 5;
    localparam int GNT_W   = 2;

    logic                     clk;
    logic                     reset_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LED_W-1:0] req_data;
    logic [NUM_REQ-1:0]       ack;
    logic                     busy;
    logic [GNT_W-1:0]         last_grant;
    logic                     rb_err;

    ulight_fifo_led_pio_arbiter_if pio_if ();

    ulight_fifo_led_pio_arbiter #(
        .NUM_REQ (NUM_REQ),
        .LED_W   (LED_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .pio        (pio_if),
        .busy       (busy),
        .last_grant (last_grant),
        .rb_err     (rb_err)
    );

    // PIO register model: latches writedata on a write, reads back the latch.
    logic [LED_W-1:0] out_port = 5'h00;
    logic             rd_force_zero = 1'b0;

    always @(posedge clk) begin
        if (pio_if.pio_chipselect && !pio_if.pio_write_n) begin
            out_port <= pio_if.pio_writedata[LED_W-1:0];
        end
    end

    assign pio_if.pio_readdata = rd_force_zero ? 32'h0000_0000 : {27'h0, out_port};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    logic exp_rb_err = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cs"},      32'(pio_if.pio_chipselect), 32'h1 & 32'h0);
        check({tag, "_write_n"}, 32'(pio_if.pio_write_n),    32'h1);
        check({tag, "_busy"},    32'(busy),                  32'h0);
        check({tag, "_ack"},     32'(ack),                   32'h0);
        check({tag, "_addr"},    32'(pio_if.pio_address),    32'h0);
    endtask

    // One full transaction starting in an IDLE cycle (#1 after an edge).
    task automatic run_txn(input string tag, input logic [3:0] r, input logic [19:0] d,
                           input int g, input logic [4:0] v);
        logic [3:0] exp_ack;
        exp_ack  = 4'b0001 << g;
        req      = r;
        req_data = d;
        @(posedge clk); #1;
        check({tag, "_wr_cs"},   32'(pio_if.pio_chipselect), 32'h1);
        check({tag, "_wr_wn"},   32'(pio_if.pio_write_n),    32'h0);
        check({tag, "_wr_data"}, pio_if.pio_writedata,       {27'h0, v});
        check({tag, "_wr_busy"}, 32'(busy),                  32'h1);
        check({tag, "_wr_ack"},  32'(ack),                   32'h0);
`ifdef LED_PIO_ARB_READBACK_EN
        @(posedge clk); #1;
        check({tag, "_rd_cs"},   32'(pio_if.pio_chipselect), 32'h1);
        check({tag, "_rd_wn"},   32'(pio_if.pio_write_n),    32'h1);
        check({tag, "_rd_ack"},  32'(ack),                   32'h0);
`endif
        @(posedge clk); #1;
        check({tag, "_ack"},     32'(ack),                   32'(exp_ack));
        check({tag, "_ack_cs"},  32'(pio_if.pio_chipselect), 32'h0);
        check({tag, "_ack_wn"},  32'(pio_if.pio_write_n),    32'h1);
        check({tag, "_lgrant"},  32'(last_grant),            32'(g));
        check({tag, "_pio_out"}, 32'(out_port),              32'(v));
        check({tag, "_rb_err"},  32'(rb_err),                32'(exp_rb_err));
        @(posedge clk); #1;
        check_idle({tag, "_post"});
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [19:0] data;
        int          g;
        logic [4:0]  val;
    } vec_t;

    vec_t vecs [12];

    initial begin
        // Data layout per record: {data3, data2, data1, data0}.
        vecs[0]  = '{4'b1111, {5'h04, 5'h03, 5'h02, 5'h01}, 0, 5'h01};
        vecs[1]  = '{4'b1111, {5'h04, 5'h03, 5'h02, 5'h01}, 1, 5'h02};
        vecs[2]  = '{4'b1111, {5'h04, 5'h03, 5'h02, 5'h01}, 2, 5'h03};
        vecs[3]  = '{4'b1111, {5'h04, 5'h03, 5'h02, 5'h01}, 3, 5'h04};
        vecs[4]  = '{4'b1111, {5'h04, 5'h03, 5'h02, 5'h01}, 0, 5'h01};
        vecs[5]  = '{4'b0001, {5'h00, 5'h00, 5'h00, 5'h15}, 0, 5'h15};
        vecs[6]  = '{4'b0100, {5'h00, 5'h0A, 5'h00, 5'h00}, 2, 5'h0A};
        vecs[7]  = '{4'b1001, {5'h1F, 5'h00, 5'h00, 5'h07}, 3, 5'h1F};
        vecs[8]  = '{4'b1001, {5'h1F, 5'h00, 5'h00, 5'h07}, 0, 5'h07};
        vecs[9]  = '{4'b1010, {5'h03, 5'h00, 5'h11, 5'h00}, 1, 5'h11};
        vecs[10] = '{4'b0110, {5'h00, 5'h13, 5'h0C, 5'h00}, 2, 5'h13};
        vecs[11] = '{4'b0011, {5'h00, 5'h00, 5'h01, 5'h1E}, 0, 5'h1E};

        reset_n  = 1'b0;
        req      = 4'b0000;
        req_data = 20'h00000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_writedata", pio_if.pio_writedata, 32'h0);
        check("rst_lgrant",    32'(last_grant),      32'h0);
        check("rst_rb_err",    32'(rb_err),          32'h0);
        check_idle("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // No request: stays idle.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_idle($sformatf("noreq%0d", i));
        end

        // Table: round robin, wrap and data path.
        for (int i = 0; i < 12; i++) begin
            run_txn($sformatf("v%0d", i), vecs[i].req, vecs[i].data, vecs[i].g, vecs[i].val);
        end

        // Data captured at grant: req/req_data change right after grant.
        req      = 4'b0100;
        req_data = {5'h00, 5'h09, 5'h00, 5'h00};
        @(posedge clk); #1;
        req      = 4'b0000;
        req_data = 20'hFFFFF;
        check("cap_wr_data", pio_if.pio_writedata, 32'h0000_0009);
        check("cap_wr_cs",   32'(pio_if.pio_chipselect), 32'h1);
`ifdef LED_PIO_ARB_READBACK_EN
        @(posedge clk); #1;
`endif
        @(posedge clk); #1;
        check("cap_ack",     32'(ack),      32'h4);
        check("cap_pio_out", 32'(out_port), 32'h09);
        @(posedge clk); #1;
        check_idle("cap_post");
        @(posedge clk); #1;
        check_idle("cap_post2");

        // Reset during WRITE: pointer is 3, so requester 3 is granted first.
        req      = 4'b1001;
        req_data = {5'h1A, 5'h00, 5'h00, 5'h0B};
        @(posedge clk); #1;
        check("mid_wr_data", pio_if.pio_writedata, 32'h0000_001A);
        reset_n = 1'b0;
        #1;
        check("mid_rst_wd",     pio_if.pio_writedata, 32'h0);
        check("mid_rst_lgrant", 32'(last_grant),      32'h0);
        check_idle("mid_rst");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_idle($sformatf("mid_rst_hold%0d", i));
        end
        @(negedge clk);
        reset_n = 1'b1;
        // Pointer back at 0: requester 0 is served fresh.
        run_txn("post_rst", 4'b1001, {5'h1A, 5'h00, 5'h00, 5'h0B}, 0, 5'h0B);
        req = 4'b0000;

`ifdef LED_PIO_ARB_READBACK_EN
        // Readback fault: PIO returns 0 while 5'h1F is written.
        rd_force_zero = 1'b1;
        req      = 4'b0001;
        req_data = {5'h00, 5'h00, 5'h00, 5'h1F};
        @(posedge clk); #1;
        check("rb_wr_cs", 32'(pio_if.pio_chipselect), 32'h1);
        check("rb_wr_wn", 32'(pio_if.pio_write_n),    32'h0);
        @(posedge clk); #1;
        check("rb_rd_cs",  32'(pio_if.pio_chipselect), 32'h1);
        check("rb_rd_wn",  32'(pio_if.pio_write_n),    32'h1);
        check("rb_rd_err", 32'(rb_err),                32'h0);
        @(posedge clk); #1;
        req = 4'b0000;
        check("rb_ack", 32'(ack),    32'h1);
        check("rb_err", 32'(rb_err), 32'h1);
        rd_force_zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("rb_sticky%0d", i), 32'(rb_err), 32'h1);
        end
`endif

        @(posedge clk); #1;
        check_idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ulight_fifo_led_pio_arbiter
